// File: rtl/tile_match_pkg.sv
// Shared board constants, FSM state type, pair layout and tile-word helpers
// for the tile-matching game controller.
package tile_match_pkg;

    typedef enum logic [2:0] {
        WAIT1,
        WAIT2,
        CMP,
        HOLD,
        WON
    } state_t;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned NTILES = ROWS * COLS;
    localparam int unsigned NPAIRS = NTILES / 2;

    // Tile word layout: {color[5:0], shown, cursor}
    localparam int unsigned WORD_CUR_BIT   = 0;
    localparam int unsigned WORD_UP_BIT    = 1;
    localparam int unsigned WORD_COLOR_LSB = 2;

    // Each nonzero color appears exactly twice so matched tiles never render black.
    localparam logic [5:0] PAIR_LAYOUT [NTILES] = '{
        6'h30, 6'h0C, 6'h03, 6'h3C, 6'h33, 6'h0F, 6'h3F, 6'h15,
        6'h0C, 6'h33, 6'h30, 6'h15, 6'h03, 6'h3C, 6'h0F, 6'h3F
    };

    // XOR with perm is a bijection on 0..15, so shuffled layouts keep their pairs.
    function automatic logic [5:0] tileColor(input logic [3:0] idx, input logic [3:0] perm);
        return PAIR_LAYOUT[idx ^ perm];
    endfunction

    function automatic logic [7:0] packWord(input logic [5:0] color, input logic shown,
                                            input logic cursorHere);
        logic [7:0] w;
        w = '0;
        w[WORD_COLOR_LSB +: 6] = color;
        w[WORD_UP_BIT]         = shown;
        w[WORD_CUR_BIT]        = cursorHere;
        return w;
    endfunction

endpackage

// File: rtl/tile_match_ctrl_if.sv
// Renderer tile-state read port: renderer drives the tile index, controller
// returns the registered tile word.
interface tile_match_ctrl_if;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/tile_cursor.sv
// Board cursor: one step per pulse, clamped at the edges, priority up > down > left > right.
module tile_cursor
    import tile_match_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    output logic [3:0] cursor
);

    logic [1:0] row, col, rowNext, colNext;

    assign row = cursor[3:2];
    assign col = cursor[1:0];

    // Pick the single highest-priority move and clamp it at the board edge.
    always_comb begin
        rowNext = row;
        colNext = col;
        if (btnUp) begin
            if (row != 2'd0) rowNext = row - 2'd1;
        end else if (btnDown) begin
            if (row != 2'(ROWS - 1)) rowNext = row + 2'd1;
        end else if (btnLeft) begin
            if (col != 2'd0) colNext = col - 2'd1;
        end else if (btnRight) begin
            if (col != 2'(COLS - 1)) colNext = col + 2'd1;
        end
    end

    // Cursor register; clear (new game) wins over any move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor <= '0;
        end else if (clear) begin
            cursor <= '0;
        end else begin
            cursor <= {rowNext, colNext};
        end
    end

endmodule

// File: rtl/tile_match_ctrl.sv
// Tile-matching game controller: tile state store, pair flip/compare/hold
// sequencing, scoring and the renderer's registered tile-word read port.
module tile_match_ctrl
    import tile_match_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_sel,
    input  logic              new_game,
    tile_match_ctrl_if.slave  rdPort,
    output logic [7:0]        moves,
    output logic [3:0]        pairs_found,
    output logic              game_won,
    output logic              busy
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t             state, stateNext;
    logic [NTILES-1:0]  tileUp, tileMatched;
    logic [3:0]         lfsr, perm, idxA, idxB, cursor;
    logic [CNT_W-1:0]   holdCnt;
    logic               curFree, rdShown;
    logic               flipCur, latchA, latchB, markMatch, loadHold, hideBoth;

    tile_cursor u_cursor (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (new_game),
        .btnUp    (btn_up),
        .btnDown  (btn_down),
        .btnLeft  (btn_left),
        .btnRight (btn_right),
        .cursor   (cursor)
    );

    assign curFree = !tileUp[cursor] && !tileMatched[cursor];
    assign rdShown = tileUp[rdPort.rd_addr] | tileMatched[rdPort.rd_addr];

    // Next-state and datapath strobes for the flip/compare/hold flow.
    always_comb begin
        stateNext = state;
        flipCur   = 1'b0;
        latchA    = 1'b0;
        latchB    = 1'b0;
        markMatch = 1'b0;
        loadHold  = 1'b0;
        hideBoth  = 1'b0;
        case (state)
            WAIT1: if (btn_sel && curFree) begin
                flipCur   = 1'b1;
                latchA    = 1'b1;
                stateNext = WAIT2;
            end
            WAIT2: if (btn_sel && curFree && cursor != idxA) begin
                flipCur   = 1'b1;
                latchB    = 1'b1;
                stateNext = CMP;
            end
            CMP: begin
                if (tileColor(idxA, perm) == tileColor(idxB, perm)) begin
                    markMatch = 1'b1;
                    stateNext = (pairs_found == 4'(NPAIRS - 1)) ? WON : WAIT1;
                end else begin
                    loadHold  = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: if (holdCnt == '0) begin
                hideBoth  = 1'b1;
                stateNext = WAIT1;
            end
            WON:     stateNext = WON;
            default: stateNext = WAIT1;
        endcase
        busy     = (state == CMP) || (state == HOLD);
        game_won = (state == WON);
    end

    // FSM state register; new_game restarts from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT1;
        end else if (new_game) begin
            state <= WAIT1;
        end else begin
            state <= stateNext;
        end
    end

    // Free-running x^4+x^3+1 LFSR used as the shuffle source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 4'b1001;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    // Tile store, selected indices, hold timer and score counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm        <= '0;
            tileUp      <= '0;
            tileMatched <= '0;
            idxA        <= '0;
            idxB        <= '0;
            holdCnt     <= '0;
            moves       <= '0;
            pairs_found <= '0;
        end else if (new_game) begin
            perm        <= lfsr;
            tileUp      <= '0;
            tileMatched <= '0;
            moves       <= '0;
            pairs_found <= '0;
        end else begin
            if (flipCur) tileUp[cursor] <= 1'b1;
            if (latchA) idxA <= cursor;
            if (latchB) idxB <= cursor;
            if (state == CMP && moves != 8'hFF) moves <= moves + 8'd1;
            if (markMatch) begin
                tileMatched[idxA] <= 1'b1;
                tileMatched[idxB] <= 1'b1;
                pairs_found       <= pairs_found + 4'd1;
            end
            if (loadHold) begin
                holdCnt <= HOLD_LOAD;
            end else if (state == HOLD && holdCnt != '0) begin
                holdCnt <= holdCnt - 1'b1;
            end
            if (hideBoth) begin
                tileUp[idxA] <= 1'b0;
                tileUp[idxB] <= 1'b0;
            end
        end
    end

    // Registered tile word for the renderer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPort.rd_data <= '0;
        end else begin
            rdPort.rd_data <= packWord(tileColor(rdPort.rd_addr, perm), rdShown,
                                       (cursor == rdPort.rd_addr) && !rdShown);
        end
    end

endmodule

// File: tb/tb_tile_match_ctrl.sv
// Randomized and directed bench for tile_match_ctrl against a cycle-level
// behavioural model of the game rules.
module tb_tile_match_ctrl;
    import tile_match_pkg::*;

    localparam int unsigned HOLD_LEN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
    logic btnSel = 1'b0, newGame = 1'b0;
    logic [7:0] moves;
    logic [3:0] pairsFound;
    logic gameWon, busy;

    tile_match_ctrl_if rdBus ();

    tile_match_ctrl #(.HOLD_CYCLES(HOLD_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btnUp),
        .btn_down    (btnDown),
        .btn_left    (btnLeft),
        .btn_right   (btnRight),
        .btn_sel     (btnSel),
        .new_game    (newGame),
        .rdPort      (rdBus),
        .moves       (moves),
        .pairs_found (pairsFound),
        .game_won    (gameWon),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int busyRun = 0;

    // Game model
    bit mUp[16];
    bit mMatched[16];
    int mCursor, mPerm, mLfsr, mMoves, mPairs, mSelA, mSelB, mHoldLeft;
    bit mCmp, mWon;

    task automatic checkVal(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int colorOf(input int idx);
        return int'(PAIR_LAYOUT[(idx ^ mPerm) & 15]);
    endfunction

    function automatic int wordOf(input int addr);
        bit shown;
        shown = mUp[addr] || mMatched[addr];
        return colorOf(addr) * 4 + (shown ? 2 : 0) + ((mCursor == addr && !shown) ? 1 : 0);
    endfunction

    function automatic int partnerOf(input int idx);
        for (int j = 0; j < 16; j++)
            if (j != idx && colorOf(j) == colorOf(idx)) return j;
        return idx;
    endfunction

    function automatic bit modelBusy();
        return mCmp || (mHoldLeft > 0);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mUp[i] = 0;
            mMatched[i] = 0;
        end
        mCursor = 0; mPerm = 0; mLfsr = 9; mMoves = 0; mPairs = 0;
        mSelA = -1; mSelB = -1; mHoldLeft = 0; mCmp = 0; mWon = 0;
    endtask

    task automatic modelStep(input bit u, d, l, r, s, ng);
        int row, col;
        if (ng) begin
            for (int i = 0; i < 16; i++) begin
                mUp[i] = 0;
                mMatched[i] = 0;
            end
            mPerm = mLfsr; mCursor = 0; mMoves = 0; mPairs = 0;
            mSelA = -1; mSelB = -1; mHoldLeft = 0; mCmp = 0; mWon = 0;
        end else begin
            if (mWon) begin
            end else if (mCmp) begin
                mCmp = 0;
                if (mMoves < 255) mMoves++;
                if (colorOf(mSelA) == colorOf(mSelB)) begin
                    mMatched[mSelA] = 1;
                    mMatched[mSelB] = 1;
                    mPairs++;
                    mWon = (mPairs == 8);
                    mSelA = -1;
                end else begin
                    mHoldLeft = HOLD_LEN;
                end
            end else if (mHoldLeft > 0) begin
                mHoldLeft--;
                if (mHoldLeft == 0) begin
                    mUp[mSelA] = 0;
                    mUp[mSelB] = 0;
                    mSelA = -1;
                end
            end else if (s && !mUp[mCursor] && !mMatched[mCursor]) begin
                mUp[mCursor] = 1;
                if (mSelA < 0) mSelA = mCursor;
                else begin
                    mSelB = mCursor;
                    mCmp = 1;
                end
            end
            row = mCursor / 4;
            col = mCursor % 4;
            if (u) begin
                if (row > 0) row--;
            end else if (d) begin
                if (row < 3) row++;
            end else if (l) begin
                if (col > 0) col--;
            end else if (r) begin
                if (col < 3) col++;
            end
            mCursor = row * 4 + col;
        end
        mLfsr = ((mLfsr << 1) & 14) | (((mLfsr >> 3) ^ (mLfsr >> 2)) & 1);
    endtask

    // One clock: drive at negedge, step the model, check after the edge.
    task automatic cycle(input bit u, d, l, r, s, ng, input int addr);
        int expWord;
        btnUp = u; btnDown = d; btnLeft = l; btnRight = r; btnSel = s; newGame = ng;
        rdBus.rd_addr = 4'(addr);
        expWord = wordOf(addr);
        modelStep(u, d, l, r, s, ng);
        @(posedge clk);
        @(negedge clk);
        btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0; btnSel = 0; newGame = 0;
        if (busy) busyRun++;
        checkVal("rd_data", int'(rdBus.rd_data), expWord);
        checkVal("moves", int'(moves), mMoves);
        checkVal("pairs_found", int'(pairsFound), mPairs);
        checkVal("game_won", int'(gameWon), int'(mWon));
        checkVal("busy", int'(busy), int'(modelBusy()));
    endtask

    task automatic dirsToward(input int target, output bit u, d, l, r);
        u = 0; d = 0; l = 0; r = 0;
        if (target / 4 < mCursor / 4) u = 1;
        else if (target / 4 > mCursor / 4) d = 1;
        else if (target % 4 < mCursor % 4) l = 1;
        else if (target % 4 > mCursor % 4) r = 1;
    endtask

    task automatic goTo(input int target);
        bit u, d, l, r;
        for (int g = 0; g < 8 && mCursor != target; g++) begin
            dirsToward(target, u, d, l, r);
            cycle(u, d, l, r, 0, 0, mCursor);
        end
    endtask

    task automatic waitIdle();
        for (int g = 0; g < 40 && modelBusy(); g++) cycle(0, 0, 0, 0, 0, 0, mCursor);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) cycle(0, 0, 0, 0, 0, 0, a);
    endtask

    // Select a mismatched pair a/b; returns them plus a third free tile c.
    task automatic pickMismatch(output int a, b, c);
        a = -1; b = -1; c = -1;
        for (int i = 0; i < 16; i++)
            if (!mMatched[i] && !mUp[i]) begin
                if (a < 0) a = i;
                else if (b < 0 && colorOf(i) != colorOf(a)) b = i;
                else if (c < 0 && i != a) c = i;
            end
        if (c == b) c = -1;
        for (int i = 0; i < 16 && c < 0; i++)
            if (!mMatched[i] && i != a && i != b) c = i;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int a, b, c, ta, tb;
        bit u, d, l, r, selDone;
        rdBus.rd_addr = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkVal("rst_rd_data", int'(rdBus.rd_data), 0);
        checkVal("rst_moves", int'(moves), 0);
        checkVal("rst_pairs", int'(pairsFound), 0);
        checkVal("rst_won", int'(gameWon), 0);
        checkVal("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Layout sweep after reset: only tile 0 carries the cursor bit.
        sweep();

        // Cursor clamping and priority.
        repeat (5) cycle(0, 0, 0, 1, 0, 0, mCursor);
        repeat (2) cycle(0, 1, 0, 0, 0, 0, mCursor);
        cycle(1, 0, 1, 0, 0, 0, mCursor);
        cycle(0, 0, 0, 0, 0, 0, 7);
        cycle(0, 0, 0, 0, 0, 0, 11);

        // Matching pair, then reselect of a matched tile.
        ta = mCursor;
        tb = partnerOf(ta);
        cycle(0, 0, 0, 0, 1, 0, ta);
        goTo(tb);
        cycle(0, 0, 0, 0, 1, 0, tb);
        cycle(0, 0, 0, 0, 0, 0, ta);
        cycle(0, 0, 0, 0, 0, 0, tb);
        cycle(0, 0, 0, 0, 1, 0, tb);
        cycle(0, 0, 0, 0, 0, 0, tb);

        // Mismatch: busy length, hide timing, select ignored during hold.
        pickMismatch(a, b, c);
        goTo(a);
        cycle(0, 0, 0, 0, 1, 0, a);
        goTo(b);
        busyRun = 0;
        cycle(0, 0, 0, 0, 1, 0, a);
        selDone = 0;
        for (int k = 0; k < 12; k++) begin
            if (!selDone && k < 8) begin
                if (mCursor != c) begin
                    dirsToward(c, u, d, l, r);
                    cycle(u, d, l, r, 0, 0, (k % 2 == 0) ? a : b);
                end else begin
                    cycle(0, 0, 0, 0, 1, 0, c);
                    selDone = 1;
                end
            end else begin
                cycle(0, 0, 0, 0, 0, 0, (k % 2 == 0) ? a : b);
            end
        end
        checkVal("busy_len", busyRun, 9);
        sweep();

        // Clear the board.
        for (int i = 0; i < 16; i++) begin
            if (!mMatched[i]) begin
                ta = i;
                tb = partnerOf(i);
                goTo(ta);
                cycle(0, 0, 0, 0, 1, 0, ta);
                goTo(tb);
                cycle(0, 0, 0, 0, 1, 0, tb);
                waitIdle();
            end
        end
        cycle(0, 0, 0, 0, 0, 0, mCursor);
        checkVal("won_pairs", int'(pairsFound), 8);
        checkVal("won_flag", int'(gameWon), 1);
        cycle(0, 0, 0, 0, 1, 0, mCursor);
        cycle(0, 0, 0, 0, 0, 0, 5);

        // New game from WON: counters clear, reshuffled layout.
        cycle(0, 0, 0, 1, 1, 1, 3);
        sweep();

        // Reset in the middle of a hold.
        pickMismatch(a, b, c);
        goTo(a);
        cycle(0, 0, 0, 0, 1, 0, a);
        goTo(b);
        cycle(0, 0, 0, 0, 1, 0, a);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, a);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("arst_rd_data", int'(rdBus.rd_data), 0);
        checkVal("arst_moves", int'(moves), 0);
        checkVal("arst_busy", int'(busy), 0);
        checkVal("arst_pairs", int'(pairsFound), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        sweep();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Random play.
        for (int n = 0; n < 2500; n++) begin
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 1) == 0) ? mCursor : int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
